cordic_dual_mode_engine: RTL and testbench
==========================================

// Module: cordic_dual_mode_engine
// PURPOSE
//  Iterative CORDIC engine (one micro-rotation per cycle), run-time selectable rotation or vectoring mode.
//  Angles use full-circle binary format (2^ANGLE_WIDTH = one turn), so any angle code wraps with no reduction loop.
//  Valid/ready handshakes on both sides, a tag passthrough, optional gain compensation and output saturation.
//  Sits between sample sources (NCO, mixers, polar converters) and downstream DSP.
// PARAMETERS
//  WIDTH        16  signed x/y width, two's complement
//  ITERATIONS   15  micro-rotations; legal range 1..min(WIDTH, ANGLE_WIDTH-2)
//  ANGLE_WIDTH  32  binary-angle width; 0x4000_0000 = 90 deg at 32 bits
//  GAIN_COMP    1   1: multiply result by K = 0.607253 (17-bit constant 0x09B75, Q1.16); 0: raw CORDIC gain
//  TAG_WIDTH    4   user tag carried from input to output
// PORTS
//  clock      in   1            rising-edge clock
//  reset_n    in   1            asynchronous, active-low reset
//  in_valid   in   1            input request
//  in_ready   out  1            engine can accept a request
//  in_mode    in   1            0 = rotation, 1 = vectoring
//  in_x       in   WIDTH        input x
//  in_y       in   WIDTH        input y
//  in_angle   in   ANGLE_WIDTH  rotation angle (binary angle); ignored in vectoring mode
//  in_tag     in   TAG_WIDTH    user tag
//  out_valid  out  1            result available
//  out_ready  in   1            downstream accepts the result
//  out_x      out  WIDTH        rotation: rotated x; vectoring: magnitude
//  out_y      out  WIDTH        rotation: rotated y; vectoring: residual y (near 0)
//  out_angle  out  ANGLE_WIDTH  rotation: residual z; vectoring: atan2(in_y, in_x) as binary angle
//  out_tag    out  TAG_WIDTH    tag of this result
//  out_sat    out  1            out_x or out_y was clipped
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0. All other outputs and internal registers go to 0.
//  FSM:
//   IDLE -> ITER on in_valid&&in_ready.
//   ITER -> SCALE when iteration count = ITERATIONS-1.
//   SCALE -> OUT.
//   OUT -> IDLE on out_ready.
//  in_ready = (state==IDLE). Accepted fields, mode and tag are registered on the accepting edge.
//  Latency: out_valid rises exactly ITERATIONS+2 cycles after the accept edge (accept 1, ITER N, SCALE 1).
//   Minimum request spacing is ITERATIONS+3 cycles.
//  Datapath x/y are WIDTH+2 bits. Inputs are sign-extended. Shifts are arithmetic (>>> i at iteration i).
//  Angle arithmetic is modulo 2^ANGLE_WIDTH. Wrap-around is intended and never flagged.
//  atan table: round(atan(2^-i)/(2*pi) * 2^ANGLE_WIDTH), generated at elaboration.
//  Pre-rotation on accept, rotation mode: if angle bits [MSB:MSB-1] are 01 or 10 (90..270 deg), negate x and y and
//   set z = angle - 0x8000..0 (180 deg); otherwise z = angle. Residual lies in [-90,90) deg.
//  Pre-rotation on accept, vectoring mode: if x < 0, negate x and y and set z = 180 deg; otherwise z = 0.
//  x = -(-2^(WIDTH-1)) is representable thanks to the guard bits.
//  Per iteration, direction d = +1 if (rotation: z >= 0) or (vectoring: y < 0), else -1.
//   x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan[i].
//  SCALE: if GAIN_COMP, x,y = (v*0x09B75 + 2^15) >>> 16 (round half up). Then each of x,y saturates symmetrically
//   to +/-(2^(WIDTH-1)-1). out_sat = OR of both clip events.
//  OUT: all out_* are registered and held stable while out_valid && !out_ready.
//  out_valid drops on the edge where out_ready is sampled high. Results are never dropped or duplicated.
//  in_valid during ITER/SCALE/OUT is ignored (in_ready=0). The requester must hold the request until accepted.
//  reset_n low at any point aborts the operation immediately. No partial result is emitted after release.
//  ITERATIONS out of legal range is an elaboration error ($error in generate).
// TESTING (WIDTH=16, ITERATIONS=15, ANGLE_WIDTH=32, GAIN_COMP=1; tolerance +/-3 LSB on x/y, +/-0x20000 on angle)
//  Rotation: x=0x4000, y=0, angle=0x4000_0000 (90 deg) -> out_x~0x0000, out_y~0x4000, out_valid at accept+17.
//  Wrap: x=0x4000, y=0, angle=0xC000_0000 (270 = -90 deg) -> out_x~0, out_y~0xC000.
//   Repeat with angle=0x8000_0000 -> out_x~0xC000, out_y~0.
//  Vectoring: x=0x3000, y=0x4000 -> out_x~0x5000, out_y~0, out_angle~0x25C8_09EF (53.13 deg).
//   Repeat with x=0xC000, y=0 -> out_x~0x4000, out_angle~0x8000_0000.
//  Saturation: rotation, x=y=0x7FFF, angle=0x2000_0000 -> out_x~0, out_y=0x7FFF, out_sat=1.
//  Handshake: hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0, in_valid ignored.
//   Then out_ready=1 for 1 cycle -> out_valid=0, in_ready=1 next cycle. Tag 0xA is returned unchanged.
//  Reset: assert reset_n=0 at ITER cycle 7 -> out_valid=0 and in_ready=1 immediately.
//   A new request after release completes normally with the correct result.

Source files
------------

// File: rtl/cordic_dual_mode_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_dual_mode_engine
//  Description : Iterative CORDIC (one micro-rotation per cycle), rotation or
//                vectoring mode, binary-angle format, gain compensation and
//                symmetric output saturation behind valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_dual_mode_engine #(
    parameter int WIDTH       = 16,
    parameter int ITERATIONS  = 15,
    parameter int ANGLE_WIDTH = 32,
    parameter int GAIN_COMP   = 1,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [WIDTH-1:0]       in_x,
    input  logic [WIDTH-1:0]       in_y,
    input  logic [ANGLE_WIDTH-1:0] in_angle,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_x,
    output logic [WIDTH-1:0]       out_y,
    output logic [ANGLE_WIDTH-1:0] out_angle,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_sat
);

    localparam int c_dw = WIDTH + 2;
    localparam int c_pw = c_dw + 18;
    localparam int c_cw = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_iter  = 2'd1;
    localparam logic [1:0] c_st_scale = 2'd2;
    localparam logic [1:0] c_st_out   = 2'd3;

    localparam logic [ANGLE_WIDTH-1:0] c_half_turn = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
    localparam logic signed [c_pw-1:0] c_lim_hi    = (c_pw'(1) <<< (WIDTH-1)) - c_pw'(1);
    localparam logic signed [c_pw-1:0] c_lim_lo    = -c_lim_hi;

    if (ITERATIONS < 1 || ITERATIONS > WIDTH || ITERATIONS > ANGLE_WIDTH - 2) begin : g_bad_iter
        $error("cordic_dual_mode_engine: ITERATIONS out of legal range");
    end

    function automatic logic [ANGLE_WIDTH-1:0] atan_code(input int idx);
        real v;
        v = $atan(2.0 ** (-idx)) / (2.0 * 3.14159265358979323846) * (2.0 ** ANGLE_WIDTH);
        return ANGLE_WIDTH'(longint'(v));
    endfunction

    // Returns {clip, value} with the value limited to +/-(2^(WIDTH-1)-1).
    function automatic logic [WIDTH:0] saturate(input logic signed [c_pw-1:0] v);
        logic [WIDTH:0] res;
        if (v > c_lim_hi)      res = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        else if (v < c_lim_lo) res = {1'b1, 1'b1, {(WIDTH-2){1'b0}}, 1'b1};
        else                   res = {1'b0, v[WIDTH-1:0]};
        return res;
    endfunction

    logic [ANGLE_WIDTH-1:0] w_atan_tab [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam logic [ANGLE_WIDTH-1:0] c_atan = atan_code(g);
        assign w_atan_tab[g] = c_atan;
    end

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [c_cw-1:0]         r_iter;
    logic                    r_mode;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic signed [c_dw-1:0]  r_x;
    logic signed [c_dw-1:0]  r_y;
    logic [ANGLE_WIDTH-1:0]  r_z;
    logic [WIDTH-1:0]        r_out_x;
    logic [WIDTH-1:0]        r_out_y;
    logic [ANGLE_WIDTH-1:0]  r_out_angle;
    logic [TAG_WIDTH-1:0]    r_out_tag;
    logic                    r_out_sat;

    logic signed [c_dw-1:0]  w_in_x;
    logic signed [c_dw-1:0]  w_in_y;
    logic                    w_flip;
    logic signed [c_dw-1:0]  w_pre_x;
    logic signed [c_dw-1:0]  w_pre_y;
    logic [ANGLE_WIDTH-1:0]  w_pre_z;
    logic                    w_dir_pos;
    logic signed [c_dw-1:0]  w_xs;
    logic signed [c_dw-1:0]  w_ys;
    logic signed [c_dw-1:0]  w_x_next;
    logic signed [c_dw-1:0]  w_y_next;
    logic [ANGLE_WIDTH-1:0]  w_z_next;
    logic signed [c_pw-1:0]  w_scl_x;
    logic signed [c_pw-1:0]  w_scl_y;
    logic [WIDTH:0]          w_sat_x;
    logic [WIDTH:0]          w_sat_y;

    // Pre-rotation folds the input into the +/-90 deg convergence range.
    always_comb begin
        w_in_x  = {{2{in_x[WIDTH-1]}}, in_x};
        w_in_y  = {{2{in_y[WIDTH-1]}}, in_y};
        w_flip  = in_mode ? in_x[WIDTH-1] : (in_angle[ANGLE_WIDTH-1] ^ in_angle[ANGLE_WIDTH-2]);
        w_pre_x = w_flip ? -w_in_x : w_in_x;
        w_pre_y = w_flip ? -w_in_y : w_in_y;
        if (in_mode) w_pre_z = w_flip ? c_half_turn : '0;
        else         w_pre_z = w_flip ? (in_angle - c_half_turn) : in_angle;
    end

    always_comb begin
        w_dir_pos = r_mode ? r_y[c_dw-1] : ~r_z[ANGLE_WIDTH-1];
        w_xs      = r_x >>> r_iter;
        w_ys      = r_y >>> r_iter;
        w_x_next  = w_dir_pos ? (r_x - w_ys) : (r_x + w_ys);
        w_y_next  = w_dir_pos ? (r_y + w_xs) : (r_y - w_xs);
        w_z_next  = w_dir_pos ? (r_z - w_atan_tab[r_iter]) : (r_z + w_atan_tab[r_iter]);
    end

    if (GAIN_COMP != 0) begin : g_gain
        localparam logic signed [c_pw-1:0] c_k     = c_pw'(17'h09B75);
        localparam logic signed [c_pw-1:0] c_round = c_pw'(32'h0000_8000);
        assign w_scl_x = (c_pw'(r_x) * c_k + c_round) >>> 16;
        assign w_scl_y = (c_pw'(r_y) * c_k + c_round) >>> 16;
    end else begin : g_no_gain
        assign w_scl_x = c_pw'(r_x);
        assign w_scl_y = c_pw'(r_y);
    end

    assign w_sat_x = saturate(w_scl_x);
    assign w_sat_y = saturate(w_scl_y);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= c_st_idle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (in_valid) w_state_next = c_st_iter;
            c_st_iter:  if (r_iter == c_cw'(ITERATIONS - 1)) w_state_next = c_st_scale;
            c_st_scale: w_state_next = c_st_out;
            c_st_out:   if (out_ready) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_out);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iter      <= '0;
            r_mode      <= 1'b0;
            r_tag       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_angle <= '0;
            r_out_tag   <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_iter <= '0;
                        r_mode <= in_mode;
                        r_tag  <= in_tag;
                        r_x    <= w_pre_x;
                        r_y    <= w_pre_y;
                        r_z    <= w_pre_z;
                    end
                end
                c_st_iter: begin
                    r_x    <= w_x_next;
                    r_y    <= w_y_next;
                    r_z    <= w_z_next;
                    r_iter <= r_iter + c_cw'(1);
                end
                c_st_scale: begin
                    r_out_x     <= w_sat_x[WIDTH-1:0];
                    r_out_y     <= w_sat_y[WIDTH-1:0];
                    r_out_sat   <= w_sat_x[WIDTH] | w_sat_y[WIDTH];
                    r_out_angle <= r_z;
                    r_out_tag   <= r_tag;
                end
                default: ;
            endcase
        end
    end

    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_angle = r_out_angle;
    assign out_tag   = r_out_tag;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_cordic_dual_mode_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_dual_mode_engine
//  Description : Self-checking bench; floating-point trig reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_dual_mode_engine;

    localparam int  WIDTH       = 16;
    localparam int  ITERATIONS  = 15;
    localparam int  ANGLE_WIDTH = 32;
    localparam int  TAG_WIDTH   = 4;
    localparam real PI          = 3.14159265358979323846;
    localparam real TURN        = 4294967296.0;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   in_mode = 1'b0;
    logic [WIDTH-1:0]       in_x = '0;
    logic [WIDTH-1:0]       in_y = '0;
    logic [ANGLE_WIDTH-1:0] in_angle = '0;
    logic [TAG_WIDTH-1:0]   in_tag = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [WIDTH-1:0]       out_x;
    logic [WIDTH-1:0]       out_y;
    logic [ANGLE_WIDTH-1:0] out_angle;
    logic [TAG_WIDTH-1:0]   out_tag;
    logic                   out_sat;

    cordic_dual_mode_engine #(
        .WIDTH(WIDTH), .ITERATIONS(ITERATIONS), .ANGLE_WIDTH(ANGLE_WIDTH),
        .GAIN_COMP(1), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_angle(out_angle),
        .out_tag(out_tag), .out_sat(out_sat)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference results of the current request
    longint          exp_x, exp_y;
    logic            clip_x, clip_y;
    logic [31:0]     exp_ang;
    real             exp_mag;

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal math: rotate by the angle, or take magnitude/atan2; unity gain.
    task automatic model(input logic mode, input int x, input int y, input logic [31:0] ang);
        real th, rx, ry;
        if (!mode) begin
            th      = real'(longint'(ang)) * 2.0 * PI / TURN;
            rx      = x * $cos(th) - y * $sin(th);
            ry      = x * $sin(th) + y * $cos(th);
            exp_ang = 32'h0;
        end else begin
            rx = $sqrt(real'(x) * x + real'(y) * y);
            ry = 0.0;
            th = $atan2(real'(y), real'(x));
            if (th < 0.0) th = th + 2.0 * PI;
            exp_ang = 32'(longint'(th / (2.0 * PI) * TURN));
        end
        exp_mag = $sqrt(rx * rx + ry * ry);
        exp_x   = longint'(rx);
        exp_y   = longint'(ry);
        clip_x  = (exp_x > 32767) || (exp_x < -32767);
        clip_y  = (exp_y > 32767) || (exp_y < -32767);
        if (exp_x > 32767)  exp_x = 32767;
        if (exp_x < -32767) exp_x = -32767;
        if (exp_y > 32767)  exp_y = 32767;
        if (exp_y < -32767) exp_y = -32767;
    endtask

    // Presents a request, waits for acceptance and then for out_valid.
    // Entered and left #1 after a rising edge.
    task automatic send(input logic mode, input int x, input int y, input logic [31:0] ang,
                        input logic [3:0] tag);
        int guard;
        int lat;
        in_valid = 1'b1;
        in_mode  = mode;
        in_x     = WIDTH'(x);
        in_y     = WIDTH'(y);
        in_angle = ang;
        in_tag   = tag;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
        check_val("latency", longint'(lat), longint'(ITERATIONS + 2));
    endtask

    task automatic check_result(input string nm, input logic mode, input logic [3:0] tag,
                                input longint tol_xy, input longint tol_ang);
        check_val({nm, "_x"}, longint'($signed(out_x)), exp_x, clip_x ? 0 : tol_xy);
        check_val({nm, "_y"}, longint'($signed(out_y)), exp_y, clip_y ? 0 : tol_xy);
        check_val({nm, mode ? "_angle_err" : "_resid"},
                  longint'($signed(out_angle - exp_ang)), 0, tol_ang);
        check_val({nm, "_sat"}, longint'(out_sat), longint'(clip_x | clip_y));
        check_val({nm, "_tag"}, longint'(out_tag), longint'(tag));
    endtask

    task automatic run_case(input string nm, input logic mode, input int x, input int y,
                            input logic [31:0] ang, input logic [3:0] tag,
                            input longint tol_xy, input longint tol_ang);
        model(mode, x, y, ang);
        send(mode, x, y, ang, tag);
        check_result(nm, mode, tag, tol_xy, tol_ang);
        @(posedge clock); #1;
    endtask

    initial begin
        int          rx, ry, hold_cnt;
        logic [31:0] ra;
        logic        rm;
        longint      atol;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_in_ready", longint'(in_ready), 1);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_out_x", longint'(out_x), 0);
        check_val("rst_out_angle", longint'(out_angle), 0);
        check_val("rst_out_sat", longint'(out_sat), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_case("rot90",  1'b0, 32'h4000, 0, 32'h4000_0000, 4'h1, 3, 32'h20000);
        run_case("rot270", 1'b0, 32'h4000, 0, 32'hC000_0000, 4'h2, 3, 32'h20000);
        run_case("rot180", 1'b0, 32'h4000, 0, 32'h8000_0000, 4'h3, 3, 32'h20000);
        run_case("vec34",  1'b1, 32'h3000, 32'h4000, 32'h0, 4'h4, 3, 32'h20000);
        run_case("vecneg", 1'b1, -16384, 0, 32'h1234_5678, 4'h5, 3, 32'h20000);
        run_case("sat",    1'b0, 32'h7FFF, 32'h7FFF, 32'h2000_0000, 4'h6, 3, 32'h20000);
        run_case("rotneg", 1'b0, -32768, 0, 32'h0, 4'h7, 3, 32'h20000);

        // Random rotation/vectoring; magnitude kept below the clip level.
        for (int i = 0; i < 40; i++) begin
            rm = 1'($urandom_range(1));
            rx = int'($urandom_range(40000)) - 20000;
            ry = int'($urandom_range(40000)) - 20000;
            ra = $urandom;
            if (rm && rx > -1000 && rx < 1000 && ry > -1000 && ry < 1000) rx = 1000;
            model(rm, rx, ry, ra);
            atol = rm ? (longint'(32'h20000) + longint'(8.0 / exp_mag * TURN / (2.0 * PI)))
                      : longint'(32'h20000);
            send(rm, rx, ry, ra, 4'($urandom));
            check_result("rand", rm, in_tag, 8, atol);
            @(posedge clock); #1;
        end

        // Back-pressure: results held, new requests ignored.
        out_ready = 1'b0;
        model(1'b0, 32'h2000, 32'h1000, 32'h1000_0000);
        send(1'b0, 32'h2000, 32'h1000, 32'h1000_0000, 4'hA);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = WIDTH'($urandom);
            in_mode  = 1'($urandom);
            @(posedge clock); #1;
            check_val("hs_valid", longint'(out_valid), 1);
            check_val("hs_in_ready", longint'(in_ready), 0);
            check_val("hs_tag", longint'(out_tag), 32'hA);
            check_val("hs_x", longint'($signed(out_x)), exp_x, 3);
            check_val("hs_y", longint'($signed(out_y)), exp_y, 3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check_val("hs_drop_valid", longint'(out_valid), 0);
        check_val("hs_idle_ready", longint'(in_ready), 1);
        @(posedge clock); #1;
        check_val("hs_no_ghost", longint'(in_ready), 1);

        // Reset in the middle of the iterations.
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_x     = 16'h4000;
        in_y     = 16'h0;
        in_angle = 32'h2000_0000;
        in_tag   = 4'h9;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("abort_out_valid", longint'(out_valid), 0);
        check_val("abort_in_ready", longint'(in_ready), 1);
        check_val("abort_out_tag", longint'(out_tag), 0);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        hold_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            if (out_valid) hold_cnt++;
        end
        check_val("abort_no_result", longint'(hold_cnt), 0);
        run_case("post_rst", 1'b0, 32'h4000, 0, 32'h2000_0000, 4'hB, 3, 32'h20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
